mem_arbiter: RTL and testbench

- Shares the single-ported backing memory between two requesters (req0, req1), e.g. instruction-side and data-side caches.
- Round-robin arbitration; at most one memory transaction is in flight.
- Read responses are routed back to the requester that issued the read.
- Sits between the caches and the memory model. Drives the memory's request and reset lines and consumes its one-cycle-latency read response.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/rr_select_2.sv | 23 ++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache/memory types: operation encoding, address/data widths and
// the state encoding used by the memory arbiter FSM.
package cache_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] UbitAddr;
  typedef logic [DATA_WIDTH-1:0] UbitData;

  typedef enum logic [1:0] {
    Op_INVALID = 2'd0,
    Op_READ    = 2'd1,
    Op_WRITE   = 2'd2
  } Op;

  typedef enum logic [1:0] {
    ArbState_IDLE     = 2'd0,
    ArbState_ISSUE    = 2'd1,
    ArbState_WAIT_RSP = 2'd2
  } ArbState;

endpackage

// File: rtl/rr_select_2.sv
// Two-way round-robin picker (purely combinational).
//   req      : request vector, bit i set when requester i wants service
//   last_gnt : index of the requester granted most recently
//   gnt_vld  : at least one requester is asking
//   gnt_idx  : chosen requester; on a tie the one that did not win last time
module rr_select_2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    case (req)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_gnt;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported memory between two requesters with round-robin
// arbitration and a single outstanding transaction. Read data is routed back
// to the requester that issued the read.
//   clk, rst                : clock, synchronous active-high reset
//   reqN_op/addr/data       : request from requester N (Op_INVALID = idle)
//   reqN_rdy                : request N accepted at this edge
//   rspN_vld/rspN_data      : read response for requester N
//   mem_rst                 : memory reset (follows rst)
//   mem_req_op/addr/data    : registered memory request, valid one cycle
//   mem_rsp_vld/mem_rsp_data: memory read response, one cycle after request
module mem_arbiter #(
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  cache_pkg::Op          req0_op,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_rdy,
  output logic                  rsp0_vld,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  cache_pkg::Op          req1_op,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_rdy,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  mem_rst,
  output cache_pkg::Op          mem_req_op,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_vld,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
);
  import cache_pkg::*;

  ArbState               state_q, state_d;
  logic                  last_gnt_q;
  logic                  owner_q;
  Op                     op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [1:0] req_vec;
  logic       gnt_vld, gnt_idx;
  logic       idle, accept;

  assign req_vec = {req1_op != Op_INVALID, req0_op != Op_INVALID};

  rr_select_2 u_sel (
    .req      (req_vec),
    .last_gnt (last_gnt_q),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  // Grants are only offered in IDLE and never while reset is asserted.
  assign idle     = (state_q == ArbState_IDLE) && !rst;
  assign req0_rdy = idle && gnt_vld && !gnt_idx;
  assign req1_rdy = idle && gnt_vld &&  gnt_idx;
  assign accept   = req0_rdy || req1_rdy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ArbState_IDLE:     if (accept) state_d = ArbState_ISSUE;
      ArbState_ISSUE:    state_d = (op_q == Op_WRITE) ? ArbState_IDLE : ArbState_WAIT_RSP;
      ArbState_WAIT_RSP: if (mem_rsp_vld) state_d = ArbState_IDLE;
      default:           state_d = ArbState_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ArbState_IDLE;
    else     state_q <= state_d;
  end

  // last_gnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= Op_INVALID;
      addr_q     <= '0;
      data_q     <= '0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
    end else if (accept) begin
      op_q       <= gnt_idx ? req1_op   : req0_op;
      addr_q     <= gnt_idx ? req1_addr : req0_addr;
      data_q     <= gnt_idx ? req1_data : req0_data;
      owner_q    <= gnt_idx;
      last_gnt_q <= gnt_idx;
    end else if (state_q == ArbState_ISSUE) begin
      // Request lasts exactly one cycle; addr/data are left as-is.
      op_q <= Op_INVALID;
    end
  end

  assign mem_rst      = rst;
  assign mem_req_op   = op_q;
  assign mem_req_addr = addr_q;
  assign mem_req_data = data_q;

  // Stray responses outside WAIT_RSP are dropped, as is a response that
  // coincides with reset.
  assign rsp0_vld  = mem_rsp_vld && (state_q == ArbState_WAIT_RSP) && !owner_q && !rst;
  assign rsp1_vld  = mem_rsp_vld && (state_q == ArbState_WAIT_RSP) &&  owner_q && !rst;
  assign rsp0_data = mem_rsp_data;
  assign rsp1_data = mem_rsp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cache_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  Op       req0_op, req1_op;
  UbitAddr req0_addr, req1_addr;
  UbitData req0_data, req1_data;
  logic    req0_rdy, req1_rdy, rsp0_vld, rsp1_vld;
  UbitData rsp0_data, rsp1_data;
  logic    mem_rst;
  Op       mem_req_op;
  UbitAddr mem_req_addr;
  UbitData mem_req_data;
  logic    mem_rsp_vld;
  UbitData mem_rsp_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_op(req0_op), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_rdy(req0_rdy), .rsp0_vld(rsp0_vld), .rsp0_data(rsp0_data),
    .req1_op(req1_op), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_rdy(req1_rdy), .rsp1_vld(rsp1_vld), .rsp1_data(rsp1_data),
    .mem_rst(mem_rst), .mem_req_op(mem_req_op), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data)
  );

  // Memory model: one-cycle read latency, cleared by mem_rst.
  UbitData mem [256];
  logic    m_vld;
  UbitData m_data;
  logic    inject;

  always @(posedge clk) begin
    if (mem_rst) begin
      m_vld  <= 1'b0;
      m_data <= '0;
      for (int k = 0; k < 256; k++) mem[k] <= '0;
    end else begin
      m_vld <= (mem_req_op == Op_READ);
      if (mem_req_op == Op_READ)  m_data <= mem[mem_req_addr[7:0]];
      if (mem_req_op == Op_WRITE) mem[mem_req_addr[7:0]] <= mem_req_data;
    end
  end

  assign mem_rsp_vld  = m_vld | inject;
  assign mem_rsp_data = m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    Op       op0; UbitAddr a0; UbitData d0;
    Op       op1; UbitAddr a1; UbitData d1;
    logic    inj;
    logic    rdy0, rdy1;
    Op       mop; UbitAddr maddr; UbitData mdata;
    logic    rsp0, rsp1; UbitData rdata;
  } vec_t;

  vec_t tv[$];

  task automatic drive(input Op o0, input UbitAddr a0, input UbitData d0,
                       input Op o1, input UbitAddr a1, input UbitData d1);
    req0_op = o0; req0_addr = a0; req0_data = d0;
    req1_op = o1; req1_addr = a1; req1_data = d1;
  endtask

  initial begin
    rst = 1'b1;
    inject = 1'b0;
    drive(Op_WRITE, 16'h1, 32'h1, Op_READ, 16'h2, 32'h0);

    // Reset state, with both requesters asking.
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst rdy0", 32'(req0_rdy), 0);
    chk("rst rdy1", 32'(req1_rdy), 0);
    chk("rst mem_op", 32'(mem_req_op), 32'(Op_INVALID));
    chk("rst mem_addr", 32'(mem_req_addr), 0);
    chk("rst mem_data", 32'(mem_req_data), 0);
    chk("rst mem_rst", 32'(mem_rst), 1);
    chk("rst rsp0", 32'(rsp0_vld), 0);
    chk("rst rsp1", 32'(rsp1_vld), 0);

    // Per-cycle vectors; each row is applied at a falling edge.
    // Write then read-back, tie alternation, back-to-back writes, stray responses.
    tv.push_back('{Op_WRITE,  16'h05, 32'hA5, Op_INVALID, 16'h00, 32'h0, 0, 1,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_WRITE,   16'h05, 32'hA5, 0,0, 32'h00});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_READ,    16'h05, 32'h0, 0, 0,1, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_READ,    16'h05, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_INVALID, 16'h00, 32'h00, 0,1, 32'hA5});
    tv.push_back('{Op_READ,   16'h05, 32'h00, Op_READ,    16'h06, 32'h0, 0, 1,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_READ,   16'h05, 32'h00, Op_READ,    16'h06, 32'h0, 0, 0,0, Op_READ,    16'h05, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_READ,   16'h05, 32'h00, Op_READ,    16'h06, 32'h0, 0, 0,0, Op_INVALID, 16'h00, 32'h00, 1,0, 32'hA5});
    tv.push_back('{Op_READ,   16'h05, 32'h00, Op_READ,    16'h06, 32'h0, 0, 0,1, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_READ,   16'h05, 32'h00, Op_READ,    16'h06, 32'h0, 0, 0,0, Op_READ,    16'h06, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_READ,   16'h05, 32'h00, Op_READ,    16'h06, 32'h0, 0, 0,0, Op_INVALID, 16'h00, 32'h00, 0,1, 32'h00});
    tv.push_back('{Op_READ,   16'h05, 32'h00, Op_READ,    16'h06, 32'h0, 0, 1,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_READ,   16'h05, 32'h00, Op_READ,    16'h06, 32'h0, 0, 0,0, Op_READ,    16'h05, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_INVALID, 16'h00, 32'h00, 1,0, 32'hA5});
    tv.push_back('{Op_WRITE,  16'h10, 32'h3C, Op_INVALID, 16'h00, 32'h0, 0, 1,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_WRITE,  16'h11, 32'h5A, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_WRITE,   16'h10, 32'h3C, 0,0, 32'h00});
    tv.push_back('{Op_WRITE,  16'h11, 32'h5A, Op_INVALID, 16'h00, 32'h0, 0, 1,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_WRITE,  16'h12, 32'h77, Op_READ,    16'h10, 32'h0, 0, 0,0, Op_WRITE,   16'h11, 32'h5A, 0,0, 32'h00});
    tv.push_back('{Op_WRITE,  16'h12, 32'h77, Op_READ,    16'h10, 32'h0, 0, 0,1, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_WRITE,  16'h12, 32'h77, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_READ,    16'h10, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_WRITE,  16'h12, 32'h77, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_INVALID, 16'h00, 32'h00, 0,1, 32'h3C});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 1, 0,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_READ,   16'h11, 32'h00, Op_INVALID, 16'h00, 32'h0, 0, 1,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 1, 0,0, Op_READ,    16'h11, 32'h00, 0,0, 32'h00});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_INVALID, 16'h00, 32'h00, 1,0, 32'h5A});
    tv.push_back('{Op_INVALID,16'h00, 32'h00, Op_INVALID, 16'h00, 32'h0, 0, 0,0, Op_INVALID, 16'h00, 32'h00, 0,0, 32'h00});

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].op0, tv[i].a0, tv[i].d0, tv[i].op1, tv[i].a1, tv[i].d1);
      inject = tv[i].inj;
      #1;
      chk($sformatf("v%0d rdy0", i), 32'(req0_rdy), 32'(tv[i].rdy0));
      chk($sformatf("v%0d rdy1", i), 32'(req1_rdy), 32'(tv[i].rdy1));
      chk($sformatf("v%0d mem_op", i), 32'(mem_req_op), 32'(tv[i].mop));
      if (tv[i].mop != Op_INVALID)
        chk($sformatf("v%0d mem_addr", i), 32'(mem_req_addr), 32'(tv[i].maddr));
      if (tv[i].mop == Op_WRITE)
        chk($sformatf("v%0d mem_data", i), 32'(mem_req_data), 32'(tv[i].mdata));
      chk($sformatf("v%0d rsp0", i), 32'(rsp0_vld), 32'(tv[i].rsp0));
      chk($sformatf("v%0d rsp1", i), 32'(rsp1_vld), 32'(tv[i].rsp1));
      if (tv[i].rsp0) chk($sformatf("v%0d rsp0_data", i), 32'(rsp0_data), 32'(tv[i].rdata));
      if (tv[i].rsp1) chk($sformatf("v%0d rsp1_data", i), 32'(rsp1_data), 32'(tv[i].rdata));
      @(negedge clk);
    end
    inject = 1'b0;

    // Reset while a read is waiting for its response.
    drive(Op_READ, 16'h10, 32'h0, Op_INVALID, 16'h0, 32'h0);
    #1 chk("mid rdy0", 32'(req0_rdy), 1);
    @(negedge clk);
    drive(Op_INVALID, 16'h0, 32'h0, Op_INVALID, 16'h0, 32'h0);
    #1 chk("mid issue op", 32'(mem_req_op), 32'(Op_READ));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst rsp0", 32'(rsp0_vld), 0);
    chk("mid rst rsp1", 32'(rsp1_vld), 0);
    chk("mid rst mem_rst", 32'(mem_rst), 1);
    @(negedge clk);
    rst = 1'b0;
    drive(Op_READ, 16'h11, 32'h0, Op_READ, 16'h12, 32'h0);
    #1;
    chk("post rst mem_op", 32'(mem_req_op), 32'(Op_INVALID));
    chk("post rst rsp0", 32'(rsp0_vld), 0);
    chk("post rst rdy0", 32'(req0_rdy), 1);
    chk("post rst rdy1", 32'(req1_rdy), 0);
    @(negedge clk);
    drive(Op_INVALID, 16'h0, 32'h0, Op_INVALID, 16'h0, 32'h0);
    #1;
    chk("post rst issue op", 32'(mem_req_op), 32'(Op_READ));
    chk("post rst issue addr", 32'(mem_req_addr), 32'h11);
    @(negedge clk); #1;
    chk("post rst rsp0 vld", 32'(rsp0_vld), 1);
    chk("post rst rsp0 data", 32'(rsp0_data), 0);
    chk("post rst rsp1 vld", 32'(rsp1_vld), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
